// File: rtl/spi_ram_pkg.sv
// Shared opcode constants and FSM state encoding for the SPI burst RAM.
package spi_ram_pkg;

  localparam logic [1:0] OP_WRITE_BURST = 2'b00;
  localparam logic [1:0] OP_READ_BURST  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WR_DATA,
    RD_TURN,
    RD_DATA,
    DISCARD
  } state_t;

  function automatic logic f_op_legal(input logic [1:0] op);
    return (op == OP_WRITE_BURST) || (op == OP_READ_BURST);
  endfunction

endpackage

// File: rtl/spi_sp_ram.sv
// Single-port RAM: synchronous write, read-first registered read.
module spi_sp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 2**ADDR_SIZE
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_SIZE-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // No reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-style burst RAM slave: 2-bit opcode, start address, then a write or
// read data stream that runs until SS_n rises.
//
//   state   | meaning
//   IDLE    | waiting for SS_n low; first frame edge captures opcode[1]
//   CMD     | captures opcode[0] and decodes it
//   ADDR    | shifts the start address into the pointer, MSB first
//   WR_DATA | assembles write words; each full word is written then ptr++
//   RD_TURN | turnaround edge; RAM reads mem[ptr]
//   RD_DATA | shifts read words out on MISO, prefetching the next word
//   DISCARD | illegal opcode; MOSI ignored until SS_n rises
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 2**ADDR_SIZE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic cmd_err,
  output logic busy
);

  localparam int CNT_MAX = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_op_hi;
  logic                  r_is_read;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [ADDR_SIZE-1:0]  r_ptr;
  logic [ADDR_SIZE-1:0]  r_wr_addr;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_en;
  logic                  r_miso;
  logic                  r_cmd_err;

  logic [1:0]            w_opcode;
  logic                  w_addr_last;
  logic                  w_word_last;
  logic [ADDR_SIZE-1:0]  w_ram_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_wr_word;

  function automatic logic [ADDR_SIZE-1:0] f_ptr_inc(input logic [ADDR_SIZE-1:0] p);
    return (p == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  assign w_opcode    = {r_op_hi, MOSI};
  assign w_addr_last = (r_bit_cnt == CNT_W'(ADDR_SIZE - 1));
  assign w_word_last = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_wr_word   = {r_shift[DATA_WIDTH-2:0], MOSI};
  // A pending write owns the single port for its one cycle; reads never overlap it.
  assign w_ram_addr  = r_wr_en ? r_wr_addr : r_ptr;

  spi_sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (r_wr_en),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wr_data),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (SS_n) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = CMD;
        CMD:     w_next = f_op_legal(w_opcode) ? ADDR : DISCARD;
        ADDR:    if (w_addr_last) w_next = r_is_read ? RD_TURN : WR_DATA;
        RD_TURN: w_next = RD_DATA;
        WR_DATA: w_next = WR_DATA;
        RD_DATA: w_next = RD_DATA;
        DISCARD: w_next = DISCARD;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_hi   <= 1'b0;
      r_is_read <= 1'b0;
      r_bit_cnt <= '0;
      r_ptr     <= '0;
      r_wr_addr <= '0;
      r_shift   <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_miso    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_cmd_err <= 1'b0;
      r_miso    <= 1'b0;
      if (SS_n) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_op_hi   <= MOSI;
            r_bit_cnt <= '0;
          end
          CMD: begin
            r_cmd_err <= !f_op_legal(w_opcode);
            r_is_read <= (w_opcode == OP_READ_BURST);
            r_bit_cnt <= '0;
          end
          ADDR: begin
            r_ptr     <= {r_ptr[ADDR_SIZE-2:0], MOSI};
            r_bit_cnt <= w_addr_last ? '0 : r_bit_cnt + CNT_W'(1);
          end
          WR_DATA: begin
            r_shift <= w_wr_word;
            if (w_word_last) begin
              r_bit_cnt <= '0;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_ptr;
              r_wr_data <= w_wr_word;
              r_ptr     <= f_ptr_inc(r_ptr);
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          RD_TURN: r_bit_cnt <= '0;
          RD_DATA: begin
            // ptr advances only at word loads so the RAM output already holds the next word.
            if (r_bit_cnt == '0) begin
              r_miso  <= w_rd_data[DATA_WIDTH-1];
              r_shift <= {w_rd_data[DATA_WIDTH-2:0], 1'b0};
              r_ptr   <= f_ptr_inc(r_ptr);
            end else begin
              r_miso  <= r_shift[DATA_WIDTH-1];
              r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            end
            r_bit_cnt <= w_word_last ? '0 : r_bit_cnt + CNT_W'(1);
          end
          DISCARD: r_bit_cnt <= '0;
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

  assign MISO    = r_miso;
  assign cmd_err = r_cmd_err;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst with a model memory and a read-data scoreboard queue.
module tb_spi_ram_burst;

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic cmd_err;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];

  spi_ram_burst #(
    .ADDR_SIZE  (8),
    .DATA_WIDTH (8),
    .MEM_DEPTH  (256)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .cmd_err (cmd_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ss, input logic mosi);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [1:0] op, input logic [7:0] addr);
    step(1'b0, op[1]);
    step(1'b0, op[0]);
    for (int b = 7; b >= 0; b--) step(1'b0, addr[b]);
  endtask

  task automatic write_frame(input logic [7:0] addr, input int nbytes,
                             input logic [7:0] d0, input logic [7:0] d1, input int extra);
    logic [7:0] d [2];
    logic [7:0] p;
    d[0] = d0;
    d[1] = d1;
    p = addr;
    send_hdr(2'b00, addr);
    for (int k = 0; k < nbytes; k++) begin
      for (int b = 7; b >= 0; b--) step(1'b0, d[k][b]);
      model[p] = d[k];
      p = p + 8'd1;
    end
    for (int x = 0; x < extra; x++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0);
  endtask

  task automatic read_frame(input string tag, input logic [7:0] addr, input int nwords);
    logic [7:0] got;
    logic [7:0] exp;
    got = '0;
    send_hdr(2'b11, addr);
    for (int k = 0; k < nwords; k++) exp_q.push_back(model[8'(int'(addr) + k)]);
    step(1'b0, 1'($urandom_range(0, 1)));
    check({tag, "_turn_miso"}, {31'd0, MISO}, 32'd0);
    for (int i = 0; i < nwords * 8; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      got = {got[6:0], MISO};
      if (i % 8 == 7) begin
        exp = exp_q.pop_front();
        check({tag, "_word"}, {24'd0, got}, {24'd0, exp});
      end
    end
    step(1'b1, 1'b0);
    check({tag, "_end_miso"}, {31'd0, MISO}, 32'd0);
    check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int err_cnt;
    logic miso_any;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b0);

    // write then read with back-to-back words
    write_frame(8'h10, 2, 8'hA5, 8'h3C, 0);
    read_frame("wr_rd", 8'h10, 2);

    // pointer wrap
    write_frame(8'hFF, 2, 8'h11, 8'h22, 0);
    read_frame("wrap", 8'hFF, 2);

    // illegal opcode
    step(1'b0, 1'b0);
    check("ill_err_e0", {31'd0, cmd_err}, 32'd0);
    step(1'b0, 1'b1);
    check("ill_err_e1", {31'd0, cmd_err}, 32'd1);
    check("ill_busy", {31'd0, busy}, 32'd1);
    err_cnt  = 0;
    miso_any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      err_cnt  += int'(cmd_err);
      miso_any |= MISO;
    end
    check("ill_err_extra", err_cnt, 0);
    check("ill_miso", {31'd0, miso_any}, 32'd0);
    check("ill_busy_hold", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b0);
    check("ill_busy_end", {31'd0, busy}, 32'd0);
    read_frame("ill_ram", 8'h10, 2);

    // partial word is dropped
    write_frame(8'h21, 1, 8'hC3, 8'h00, 0);
    write_frame(8'h20, 1, 8'h5A, 8'h00, 3);
    read_frame("partial", 8'h20, 2);

    // reset during the 4th data bit of a write
    write_frame(8'h30, 1, 8'h99, 8'h00, 0);
    send_hdr(2'b00, 8'h30);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rstmid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    check("rstmid_miso", {31'd0, MISO}, 32'd0);
    check("rstmid_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    read_frame("rstmid_ram", 8'h30, 1);

    // one SS_n-high cycle between frames
    write_frame(8'h40, 1, 8'h77, 8'h00, 0);
    read_frame("b2b", 8'h40, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
